// File: rtl/ea_sequencer_if.sv
// rtl/ea_sequencer_if.sv - memory read bus between the EA sequencer and memory
// Signals:
//    addr  sequencer -> memory   16-bit read address
//    rd    sequencer -> memory   read strobe
//    din   memory -> sequencer   8-bit read data
//    rdy   memory -> sequencer   read completes in a cycle with rd=1 and rdy=1
interface ea_sequencer_if;
   logic [15:0] addr;
   logic        rd;
   logic [7:0]  din;
   logic        rdy;

   modport master (output addr, output rd, input din, input rdy);
   modport slave  (input addr, input rd, output din, output rdy);
endinterface

// File: rtl/ea_sequencer.sv
// rtl/ea_sequencer.sv - bc6502 effective-address sequencer
// Fetches operand and pointer bytes for the decoded addressing mode and
// produces a 16-bit effective address for the execute stage.
// Optional feature macro: EA_PAGE_PENALTY_EN (adds the FIX cycle on indexed modes).
// Ports:
//    clk, reset_n          core clock, asynchronous active-low reset
//    start, flush          begin a sequence (IDLE only) / synchronous abort to IDLE
//    imm..abs, wr_op       one-hot mode flags from the decoder, store/RMW flag
//    pc, x, y, sp          first operand address, index and stack registers
//    bus                   memory read bus (addr, rd, din, rdy)
//    pc_inc                one-cycle request to advance PC
//    ea, ea_valid          effective address and its one-cycle valid pulse
//    busy, page_cross      sequence in progress / indexed mode crossed a page
module ea_sequencer (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           flush,
   input  logic           ix,
   input  logic           iy,
   input  logic           absy,
   input  logic           zpy,
   input  logic           zi,
   input  logic           dsp,
   input  logic           sriy,
   input  logic           abs,
   input  logic           absx,
   input  logic           zp,
   input  logic           zpx,
   input  logic           imm,
   input  logic           wr_op,
   input  logic [15:0]    pc,
   input  logic [7:0]     x,
   input  logic [7:0]     y,
   input  logic [7:0]     sp,
   ea_sequencer_if.master bus,
   output logic           pc_inc,
   output logic [15:0]    ea,
   output logic           ea_valid,
   output logic           busy,
   output logic           page_cross
);

   typedef enum logic [2:0] {
      S_IDLE, S_OP_LO, S_OP_HI, S_ADD, S_PTR_LO, S_PTR_HI, S_FIX, S_DONE
   } state_t;

   typedef enum logic [3:0] {
      M_NONE, M_IMM, M_IX, M_IY, M_SRIY, M_DSP, M_ZI, M_ZPY, M_ZPX, M_ZP,
      M_ABSY, M_ABSX, M_ABS
   } mode_t;

   state_t      r_state, w_next;
   mode_t       r_mode, w_mode;
   logic [15:0] r_pc, r_ea;
   logic [7:0]  r_lo, r_hi, r_ptr;

   logic        w_indexed, w_carry, w_fix;
   logic [7:0]  w_idx, w_pg;
   logic [8:0]  w_lo_sum;
   logic [15:0] w_base, w_sum, w_ea_calc;

   // Priority encode the decoder flags
   always_comb begin
      w_mode = M_NONE;
      if      (imm)  w_mode = M_IMM;
      else if (ix)   w_mode = M_IX;
      else if (iy)   w_mode = M_IY;
      else if (sriy) w_mode = M_SRIY;
      else if (dsp)  w_mode = M_DSP;
      else if (zi)   w_mode = M_ZI;
      else if (zpy)  w_mode = M_ZPY;
      else if (zpx)  w_mode = M_ZPX;
      else if (zp)   w_mode = M_ZP;
      else if (absy) w_mode = M_ABSY;
      else if (absx) w_mode = M_ABSX;
      else if (abs)  w_mode = M_ABS;
   end

   assign w_indexed = (r_mode == M_ABSX) || (r_mode == M_ABSY) ||
                      (r_mode == M_IY)   || (r_mode == M_SRIY);
   assign w_idx     = (r_mode == M_ABSX) ? x : y;
   assign w_base    = {r_hi, r_lo};
   assign w_sum     = w_base + {8'h00, w_idx};
   // The high byte changes exactly when the low-byte add carries; this is
   // usable in OP_HI/PTR_HI before the high byte has been captured.
   assign w_lo_sum  = {1'b0, r_lo} + {1'b0, w_idx};
   assign w_carry   = w_lo_sum[8];
   // Stack-relative pointers live in page 1, all other pointers in page 0
   assign w_pg      = (r_mode == M_SRIY) ? 8'h01 : 8'h00;

`ifdef EA_PAGE_PENALTY_EN
   assign w_fix = (r_mode == M_SRIY) || w_carry || wr_op;
`else
   logic w_unused_wr_op;
   assign w_unused_wr_op = wr_op;
   assign w_fix = 1'b0;
`endif

   always_comb begin
      w_ea_calc = w_base;
      case (r_mode)
         M_NONE:                       w_ea_calc = 16'h0000;
         M_IMM:                        w_ea_calc = r_pc;
         M_ABSX, M_ABSY, M_IY, M_SRIY: w_ea_calc = w_sum;
         default:                      w_ea_calc = w_base;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      bus.addr = 16'h0000;
      bus.rd   = 1'b0;
      pc_inc   = 1'b0;
      ea_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_next = (w_mode == M_NONE || w_mode == M_IMM) ? S_DONE : S_OP_LO;
         end
         S_OP_LO: begin
            bus.addr = r_pc;
            bus.rd   = 1'b1;
            pc_inc   = bus.rdy;
            if (bus.rdy) begin
               case (r_mode)
                  M_ZP:                              w_next = S_DONE;
                  M_ZPX, M_ZPY, M_DSP, M_IX, M_SRIY: w_next = S_ADD;
                  M_ZI, M_IY:                        w_next = S_PTR_LO;
                  default:                           w_next = S_OP_HI;
               endcase
            end
         end
         S_OP_HI: begin
            bus.addr = r_pc + 16'd1;
            bus.rd   = 1'b1;
            pc_inc   = bus.rdy;
            if (bus.rdy)
               w_next = (w_indexed && w_fix) ? S_FIX : S_DONE;
         end
         S_ADD: begin
            w_next = (r_mode == M_IX || r_mode == M_SRIY) ? S_PTR_LO : S_DONE;
         end
         S_PTR_LO: begin
            bus.addr = {w_pg, r_ptr};
            bus.rd   = 1'b1;
            if (bus.rdy) w_next = S_PTR_HI;
         end
         S_PTR_HI: begin
            bus.addr = {w_pg, r_ptr + 8'd1};
            bus.rd   = 1'b1;
            if (bus.rdy)
               w_next = (w_indexed && w_fix) ? S_FIX : S_DONE;
         end
         S_FIX: w_next = S_DONE;
         S_DONE: begin
            ea_valid = 1'b1;
            pc_inc   = (r_mode == M_IMM);
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (flush) begin
         w_next   = S_IDLE;
         bus.rd   = 1'b0;
         pc_inc   = 1'b0;
         ea_valid = 1'b0;
      end
   end

   // Datapath; a flushed cycle discards whatever din carried
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode <= M_NONE;
         r_pc   <= 16'h0000;
         r_ea   <= 16'h0000;
         r_lo   <= 8'h00;
         r_hi   <= 8'h00;
         r_ptr  <= 8'h00;
      end else if (!flush) begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode <= w_mode;
                  r_pc   <= pc;
                  r_lo   <= 8'h00;
                  r_hi   <= 8'h00;
               end
            end
            S_OP_LO: begin
               if (bus.rdy) begin
                  r_lo  <= bus.din;
                  r_ptr <= bus.din;
               end
            end
            S_OP_HI:  if (bus.rdy) r_hi <= bus.din;
            S_ADD: begin
               case (r_mode)
                  M_ZPX:   r_lo <= r_lo + x;
                  M_ZPY:   r_lo <= r_lo + y;
                  M_DSP: begin
                     r_lo <= sp + r_lo;
                     r_hi <= 8'h01;
                  end
                  M_IX:    r_ptr <= r_ptr + x;
                  M_SRIY:  r_ptr <= sp + r_ptr;
                  default: ;
               endcase
            end
            S_PTR_LO: if (bus.rdy) r_lo <= bus.din;
            S_PTR_HI: if (bus.rdy) r_hi <= bus.din;
            S_DONE:   r_ea <= w_ea_calc;
            default:  ;
         endcase
      end
   end

   assign ea         = ea_valid ? w_ea_calc : r_ea;
   assign page_cross = ea_valid && w_indexed && w_carry;
   assign busy       = (r_state != S_IDLE);

endmodule
